instruction_fetch_packer: RTL and testbench

- Fetch-side producer for the AAP 16/32-bit instruction decoder.
- Reads 16-bit halfwords from instruction memory at a halfword program counter.
- Bit 0 of the first halfword selects the instruction length: 0 means 16-bit, 1 means 32-bit (a second halfword follows).
- Presents each complete instruction on fetchoutput to the decode stage under a valid/ready handshake; supports branch redirect with flush.

---
 rtl/instruction_fetch_packer_pkg.sv | 20 ++
 rtl/instruction_fetch_packer_if.sv | 32 +++
 rtl/instruction_fetch_packer_fetch_pc_counter.sv | 40 ++++
 rtl/instruction_fetch_packer.sv | 114 +++++++++++
 tb/tb_instruction_fetch_packer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_packer_pkg.sv
// Shared definitions for the AAP fetch packer and its decoder-facing bus.
// LEN_BIT is the instruction-length select bit, common to fetch and decode.
package aap_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRST   = 2'd1,
    SECOND  = 2'd2,
    PRESENT = 2'd3
  } fetch_state_e;

  localparam int HALFWORD_W = 16;
  localparam int INSTR_W    = 32;
  localparam int LEN_BIT    = 0;

  function automatic logic is_32bit(input logic [HALFWORD_W-1:0] hw);
    return hw[LEN_BIT];
  endfunction

endpackage

// File: rtl/instruction_fetch_packer_if.sv
// Memory-read and decode-handshake bundle between the fetch packer (master)
// and its environment (slave: instruction memory, decoder, branch unit).
interface instruction_fetch_packer_if #(
  parameter int ADDR_WIDTH = 24
);
  import aap_fetch_pkg::*;

  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_ack;
  logic [HALFWORD_W-1:0]   mem_rdata;

  logic [INSTR_W-1:0]      fetchoutput;
  logic                    fetch_is32;
  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic                    fetch_valid;
  logic                    decode_ready;

  logic                    branch_valid;
  logic [ADDR_WIDTH-1:0]   branch_target;

  modport master (
    output mem_req, mem_addr, fetchoutput, fetch_is32, fetch_pc, fetch_valid,
    input  mem_ack, mem_rdata, decode_ready, branch_valid, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, fetchoutput, fetch_is32, fetch_pc, fetch_valid,
    output mem_ack, mem_rdata, decode_ready, branch_valid, branch_target
  );

endinterface

// File: rtl/instruction_fetch_packer_fetch_pc_counter.sv
// Halfword program counter: load from branch target, otherwise optional +1
// with natural wrap modulo 2^ADDR_WIDTH.
module fetch_pc_counter #(
  parameter int                    ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  speedy_clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  // Load wins over increment so a redirect discards any in-flight advance.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_ONE;
    end
  end

  always_ff @(posedge speedy_clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_packer.sv
// Fetch-side producer for the AAP decoder: reads one or two halfwords per
// instruction, presents it under valid/ready, and honours branch redirects.
//
//   state   | meaning
//   IDLE    | out of reset, no request; moves to FIRST next clock
//   FIRST   | requesting the first halfword at pc
//   SECOND  | requesting the second halfword of a 32-bit instruction
//   PRESENT | instruction held on fetchoutput until decode takes it
module instruction_fetch_packer
  import aap_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                        speedy_clock,
  input  logic                        reset_n,
  instruction_fetch_packer_if.master  bus
);

  fetch_state_e          state_q, state_d;
  logic [INSTR_W-1:0]    instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_inc;
  logic                  mem_req;
  logic                  fetch_valid;

  fetch_pc_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .speedy_clock (speedy_clock),
    .reset_n      (reset_n),
    .load         (bus.branch_valid),
    .load_val     (bus.branch_target),
    .inc          (pc_inc),
    .pc           (pc)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    fpc_d       = fpc_q;
    pc_inc      = 1'b0;
    mem_req     = 1'b0;
    fetch_valid = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FIRST;
      end
      FIRST: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          instr_d[HALFWORD_W-1:0] = bus.mem_rdata;
          fpc_d  = pc;
          pc_inc = 1'b1;
          if (is_32bit(bus.mem_rdata)) begin
            state_d = SECOND;
          end else begin
            instr_d[INSTR_W-1:HALFWORD_W] = '0;
            state_d = PRESENT;
          end
        end
      end
      SECOND: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          instr_d[INSTR_W-1:HALFWORD_W] = bus.mem_rdata;
          pc_inc  = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        fetch_valid = 1'b1;
        if (bus.decode_ready) begin
          state_d = FIRST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect drops any same-cycle ack; a same-cycle transfer has already
    // completed, so only the next instruction is affected.
    if (bus.branch_valid) begin
      state_d = FIRST;
      instr_d = instr_q;
      fpc_d   = fpc_q;
      pc_inc  = 1'b0;
    end
  end

  always_ff @(posedge speedy_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      fpc_q   <= fpc_d;
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = pc;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetchoutput = instr_q;
  assign bus.fetch_pc    = fpc_q;
  assign bus.fetch_is32  = instr_q[LEN_BIT];

endmodule

// File: tb/tb_instruction_fetch_packer.sv
// Self-checking bench for instruction_fetch_packer: directed corner cases,
// a vector table of single-instruction fetches, and a randomized run.
module tb_instruction_fetch_packer;

  localparam int AW = 24;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  instruction_fetch_packer_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_fetch_packer #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (24'h000000)
  ) dut (
    .speedy_clock (clk),
    .reset_n      (rst_n),
    .bus          (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  logic [15:0] mem [logic [23:0]];

  function automatic logic [15:0] lookup(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[15:0] * 16'h9E37) ^ {a[23:16], a[23:16]} ^ 16'h3C5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives inputs for the next posedge, returns at the following negedge.
  task automatic step(input logic ack, input logic rdy, input logic br, input logic [23:0] tgt);
    bus.mem_ack       = ack;
    bus.decode_ready  = rdy;
    bus.branch_valid  = br;
    bus.branch_target = tgt;
    bus.mem_rdata     = lookup(bus.mem_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [23:0] pc;
    logic [15:0] hw0;
    logic [15:0] hw1;
    logic [31:0] exp_instr;
    logic        exp_is32;
    logic [23:0] exp_fpc;
    logic [23:0] exp_next;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vector(input int idx, input vec_t v);
    logic [23:0] p1;
    p1 = v.pc + 24'd1;
    mem[v.pc] = v.hw0;
    mem[p1]   = v.hw1;
    step(1'b0, 1'b1, 1'b1, v.pc);
    check($sformatf("vec%0d_branch_addr", idx), bus.mem_addr, v.pc);
    for (int k = 0; k < 10 && !bus.fetch_valid; k++) step(1'b1, 1'b0, 1'b0, 24'h0);
    check($sformatf("vec%0d_valid", idx), bus.fetch_valid, 1'b1);
    check($sformatf("vec%0d_instr", idx), bus.fetchoutput, v.exp_instr);
    check($sformatf("vec%0d_is32", idx), bus.fetch_is32, v.exp_is32);
    check($sformatf("vec%0d_fetch_pc", idx), bus.fetch_pc, v.exp_fpc);
    step(1'b0, 1'b1, 1'b0, 24'h0);
    check($sformatf("vec%0d_next_addr", idx), bus.mem_addr, v.exp_next);
    check($sformatf("vec%0d_valid_drop", idx), bus.fetch_valid, 1'b0);
  endtask

  initial begin
    logic [23:0] exp_pc;
    logic [15:0] h0;
    logic [31:0] exp_instr;
    logic        ack, rdy, br;
    logic [23:0] tgt, p1;
    int          xfers;

    vecs[0] = '{pc: 24'h000004, hw0: 16'h0001, hw1: 16'hBEEF, exp_instr: 32'hBEEF0001,
                exp_is32: 1'b1, exp_fpc: 24'h000004, exp_next: 24'h000006};
    vecs[1] = '{pc: 24'hFFFFFF, hw0: 16'h0003, hw1: 16'hA5A5, exp_instr: 32'hA5A50003,
                exp_is32: 1'b1, exp_fpc: 24'hFFFFFF, exp_next: 24'h000001};
    vecs[2] = '{pc: 24'h000020, hw0: 16'hFFFE, hw1: 16'h1111, exp_instr: 32'h0000FFFE,
                exp_is32: 1'b0, exp_fpc: 24'h000020, exp_next: 24'h000021};
    vecs[3] = '{pc: 24'hFFFFFF, hw0: 16'h8000, hw1: 16'h4321, exp_instr: 32'h00008000,
                exp_is32: 1'b0, exp_fpc: 24'hFFFFFF, exp_next: 24'h000000};
    vecs[4] = '{pc: 24'h7FFFFE, hw0: 16'hFFFF, hw1: 16'h0000, exp_instr: 32'h0000FFFF,
                exp_is32: 1'b1, exp_fpc: 24'h7FFFFE, exp_next: 24'h800000};

    rst_n = 1'b0;
    bus.mem_ack = 1'b0; bus.decode_ready = 1'b0; bus.branch_valid = 1'b0;
    bus.branch_target = '0; bus.mem_rdata = '0;
    mem[24'h000000] = 16'h1234;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_valid", bus.fetch_valid, 1'b0);
    check("rst_instr", bus.fetchoutput, 32'h0);
    check("rst_fetch_pc", bus.fetch_pc, 24'h0);
    check("rst_is32", bus.fetch_is32, 1'b0);

    // First 16-bit instruction after reset release: valid on the third cycle
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("c1_mem_req", bus.mem_req, 1'b1);
    check("c1_mem_addr", bus.mem_addr, 24'h0);
    check("c1_valid", bus.fetch_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("c2_valid", bus.fetch_valid, 1'b1);
    check("c2_instr", bus.fetchoutput, 32'h00001234);
    check("c2_is32", bus.fetch_is32, 1'b0);
    check("c2_fetch_pc", bus.fetch_pc, 24'h0);

    // Back-pressure: outputs held for five stalled cycles, one transfer after
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 24'h0);
      check($sformatf("hold%0d_valid", i), bus.fetch_valid, 1'b1);
      check($sformatf("hold%0d_instr", i), bus.fetchoutput, 32'h00001234);
      check($sformatf("hold%0d_fetch_pc", i), bus.fetch_pc, 24'h0);
      check($sformatf("hold%0d_mem_req", i), bus.mem_req, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 24'h0);
    check("xfer_valid_drop", bus.fetch_valid, 1'b0);
    check("xfer_mem_req", bus.mem_req, 1'b1);
    check("xfer_next_addr", bus.mem_addr, 24'h000001);

    // Delayed ack in FIRST, then reset pulse while in SECOND
    mem[24'h000001] = 16'h0007;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 24'h0);
      check($sformatf("dly%0d_mem_req", i), bus.mem_req, 1'b1);
      check($sformatf("dly%0d_mem_addr", i), bus.mem_addr, 24'h000001);
    end
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("second_mem_addr", bus.mem_addr, 24'h000002);
    check("second_valid", bus.fetch_valid, 1'b0);
    bus.mem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", bus.mem_req, 1'b0);
    check("midrst_valid", bus.fetch_valid, 1'b0);
    check("midrst_mem_addr", bus.mem_addr, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    rst_n = 1'b1;
    check("postrst_idle_req", bus.mem_req, 1'b0);
    check("postrst_valid", bus.fetch_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check("postrst_first_req", bus.mem_req, 1'b1);
    check("postrst_first_addr", bus.mem_addr, 24'h0);

    // Branch in SECOND with a same-cycle ack: partial instruction discarded
    mem[24'h000010] = 16'h0005;
    mem[24'h000100] = 16'h2222;
    step(1'b0, 1'b0, 1'b1, 24'h000010);
    check("br_first_addr", bus.mem_addr, 24'h000010);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("br_second_addr", bus.mem_addr, 24'h000011);
    step(1'b1, 1'b0, 1'b1, 24'h000100);
    check("br_valid", bus.fetch_valid, 1'b0);
    check("br_mem_req", bus.mem_req, 1'b1);
    check("br_target_addr", bus.mem_addr, 24'h000100);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check("br_no_partial", bus.fetch_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("br_new_valid", bus.fetch_valid, 1'b1);
    check("br_new_instr", bus.fetchoutput, 32'h00002222);
    check("br_new_fetch_pc", bus.fetch_pc, 24'h000100);
    step(1'b0, 1'b1, 1'b0, 24'h0);

    for (int i = 0; i < 5; i++) run_vector(i, vecs[i]);

    // Randomized run against a transaction-level model of the instruction stream
    do_reset();
    exp_pc = 24'h000000;
    xfers  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ack = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 50);
      br  = ($urandom_range(0, 99) < 5);
      tgt = ($urandom_range(0, 3) == 0) ? (24'hFFFFFF - 24'($urandom_range(0, 3)))
                                         : 24'($urandom);
      check("rnd_req_xor_valid", bus.mem_req & bus.fetch_valid, 1'b0);
      if (bus.fetch_valid && rdy) begin
        h0 = lookup(exp_pc);
        p1 = exp_pc + 24'd1;
        if (h0[0]) exp_instr = {lookup(p1), h0};
        else       exp_instr = {16'h0000, h0};
        check("rnd_instr", bus.fetchoutput, exp_instr);
        check("rnd_fetch_pc", bus.fetch_pc, exp_pc);
        check("rnd_is32", bus.fetch_is32, h0[0]);
        exp_pc = h0[0] ? (exp_pc + 24'd2) : p1;
        xfers++;
      end
      if (br) exp_pc = tgt;
      step(ack, rdy, br, tgt);
    end
    check("rnd_progress", (xfers > 100), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
